vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Display-side timing source for the VGA path. Produces the raster scan coordinates (DrawX, DrawY) and active-video qualifier (blank) that the sprite/board renderers consume, plus hs/vs sync to the monitor. The renderers register RGB one cycle after coordinates, so the syncs pass through a parameterised delay line to stay aligned with pixel data. Sits between the pixel-clock source and all renderers in the top-level video path.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_DELAY, 1, pipeline stages applied to hs/vs only (0..4)

Ports:
vga_clk  input  1  pixel clock (25 MHz nominal); single clock domain
reset  input  1  asynchronous, active-high reset
DrawX  output  10  current horizontal count (pixel column when visible)
DrawY  output  10  current vertical count (line when visible)
blank  output  1  1 = active video region (renderers draw only when 1)
hs  output  1  horizontal sync, active-low, delayed SYNC_DELAY clocks
vs  output  1  vertical sync, active-low, delayed SYNC_DELAY clocks
line_start  output  1  one-cycle pulse when DrawX==0
frame_start  output  1  one-cycle pulse when DrawX==0 && DrawY==0
frame_cnt  output  8  frame counter (see Optional Feature)

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Counters 10 bits unsigned; all totals must be <1024.
- Reset (async assert): hc=0, vc=0, run=0, all sync delay stages=1, frame_cnt=0. Outputs during reset: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_start=0, frame_start=0.
- States: IDLE (run=0) -> SCAN (run=1). First vga_clk rising edge after reset deasserts sets run=1; counters hold on that edge. Counting starts on the next edge. No return to IDLE except via reset.
- SCAN: each edge hc<=hc+1; at hc==H_TOTAL-1, hc<=0 and vc<=vc+1; at hc==H_TOTAL-1 && vc==V_TOTAL-1, vc<=0.
- DrawX=hc, DrawY=vc (direct register outputs, zero latency).
- blank = run && hc<H_VISIBLE && vc<V_VISIBLE (combinational from registers).
- hs_raw low iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751); vs_raw low iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491); both forced 1 when run=0.
- hs/vs = hs_raw/vs_raw delayed exactly SYNC_DELAY clocks; SYNC_DELAY=0 -> combinational pass-through. DrawX/DrawY/blank are never delayed.
- line_start = run && hc==0; frame_start = run && hc==0 && vc==0. First frame_start occurs in the first SCAN cycle.
- Reset mid-frame: counters, delay line and run clear immediately (async); the restart behaves exactly like power-up.

Optional Feature:
Macro VGA_FRAME_COUNTER_EN. Defined: frame_cnt increments (mod 256) on the edge where hc wraps at hc==H_TOTAL-1 && vc==V_TOTAL-1; used for cursor/selection blink. Not defined: frame_cnt tied to 8'h00, no counter register synthesised. The port exists in both builds.

Decomposition:
- vga_pkg: typedef coord_t (logic [9:0]); localparams for 640x480@60 timing defaults, H_TOTAL/V_TOTAL helper functions, board origin constants shared with renderers.
- Sub-module sync_delay_line (parameter DEPTH, reset value 1, async reset), instantiated once per sync signal.

Test Plan:
- Reset held 5 clocks, released -> DrawX=DrawY=0, blank=0, hs=vs=1 until 1 edge after release; next cycle blank=1, frame_start=1.
- Run one line -> DrawX 0..799 then 0, DrawY increments to 1 at wrap; blank=1 for exactly 640 clocks; line_start pulses once per 800 clocks.
- SYNC_DELAY=1 -> hs falls exactly 1 clock after DrawX==656, rises 1 clock after DrawX==752; SYNC_DELAY=0 -> coincident with DrawX==656/752.
- Full frame -> vs low for lines 490-491 (1600 clocks); frame_start period exactly 420000 clocks; blank=0 for all DrawY>=480.
- Assert reset at DrawX=300, DrawY=200 -> outputs return to reset values same cycle, no glitch on hs/vs; restart matches first test.
- With VGA_FRAME_COUNTER_EN run 257 frames -> frame_cnt 1,2,...,255,0,1, each change on the wrap edge; without macro frame_cnt stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA coordinate type, 640x480@60 timing defaults and board origin.
package vga_pkg;
    typedef logic [9:0] coord_t;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam coord_t BOARD_X0  = 10'd160;
    localparam coord_t BOARD_Y0  = 10'd80;
    function automatic int span_total(int vis, int fp, int sy, int bp);
        return vis + fp + sy + bp;
    endfunction
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register resetting to 1 (idle sync level); DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [DEPTH-1:0] sr;
            always_ff @(posedge clk or posedge rst)
                if (rst) sr <= '1;
                else     sr <= (sr << 1) | DEPTH'(d);
            assign q = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, blank qualifier and delayed active-low hs/vs.
// Optional frame counter enabled by defining VGA_FRAME_COUNTER_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output coord_t     DrawX,
    output coord_t     DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);
    localparam coord_t H_LAST = coord_t'(span_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
    localparam coord_t V_LAST = coord_t'(span_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
    localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
    localparam coord_t H_S0   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_S1   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t V_S0   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_S1   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    logic   run, hs_raw, vs_raw, h_wrap, v_wrap;
    coord_t hc, vc;

    assign h_wrap = hc == H_LAST;
    assign v_wrap = vc == V_LAST;

    // First edge after reset only arms run; counting begins on the following edge.
    always_ff @(posedge vga_clk or posedge reset)
        if (reset) begin
            run <= 1'b0;
            hc  <= '0;
            vc  <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            hc <= h_wrap ? '0 : hc + coord_t'(1);
            if (h_wrap) vc <= v_wrap ? '0 : vc + coord_t'(1);
        end

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign blank       = run && hc < H_VIS && vc < V_VIS;
    assign hs_raw      = !(run && hc >= H_S0 && hc < H_S1);
    assign vs_raw      = !(run && vc >= V_S0 && vc < V_S1);
    assign line_start  = run && hc == '0;
    assign frame_start = run && hc == '0 && vc == '0;

    sync_delay_line #(.DEPTH(SYNC_DELAY)) u_hs_dly (.clk(vga_clk), .rst(reset), .d(hs_raw), .q(hs));
    sync_delay_line #(.DEPTH(SYNC_DELAY)) u_vs_dly (.clk(vga_clk), .rst(reset), .d(vs_raw), .q(vs));

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] fc;
    always_ff @(posedge vga_clk or posedge reset)
        if (reset)                         fc <= '0;
        else if (run && h_wrap && v_wrap)  fc <= fc + 8'd1;
    assign frame_cnt = fc;
`else
    assign frame_cnt = '0;
`endif
endmodule
